// File: rtl/regfile_wb_arbiter.sv
// Purpose : write-back arbiter; merges ALU and mult/div results into one registered regfile write.
// Latency : ALU 1 cycle; mult/div >= 2 cycles via FIFO (1 cycle when WB_BYPASS_EN bypass applies).
// Backpr. : ALU always accepted (priority); md_ready = FIFO not full, FIFO drains only when ALU idle.
//
// Ports: clk/clr (sync active-high), alu_* result (no handshake), md_* valid/ready result,
//        wr_en/wr_addr/wr_data registered write, in_en one-hot decode, pend_cnt/busy FIFO status.
// Optional feature macro: WB_BYPASS_EN (direct mult/div write when FIFO empty and ALU idle).
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NREGS      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_addr,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          md_valid,
    output logic                          md_ready,
    input  logic [ADDR_W-1:0]             md_addr,
    input  logic [DATA_W-1:0]             md_data,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic [NREGS-1:0]              in_en,
    output logic [$clog2(FIFO_DEPTH):0]   pend_cnt,
    output logic                          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0]     fa_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]     fa_d [FIFO_DEPTH];
    logic [DATA_W-1:0]     fd_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     fd_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    logic empty, full, bypass, push, pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign md_ready = !full;

`ifdef WB_BYPASS_EN
    // Empty FIFO and idle ALU: the mult/div result goes straight to the write register.
    assign bypass = empty && !alu_valid && md_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = md_valid && !full && !bypass;
    // ALU owns the write port whenever it has a result, so the head waits.
    assign pop  = !alu_valid && !empty;

    // FIFO storage, squash and pointers
    always_comb begin
        fa_d     = fa_q;
        fd_d     = fd_q;
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        // An accepted ALU write is younger than anything buffered: older results to
        // the same register must not overwrite it later.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_valid && (fa_q[i] == alu_addr)) begin
                live_d[i] = 1'b0;
            end
        end
        if (push) begin
            fa_d[wr_ptr_q]   = md_addr;
            fd_d[wr_ptr_q]   = md_data;
            live_d[wr_ptr_q] = !(alu_valid && (md_addr == alu_addr));
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    // Write-port selection: ALU > FIFO head > bypass
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_valid) begin
            wr_en_d   = (alu_addr != '0);
            wr_addr_d = alu_addr;
            wr_data_d = alu_data;
        end else if (!empty) begin
            // Dead or r0 entries still consume the slot but never strobe the regfile.
            wr_en_d   = live_q[rd_ptr_q] && (fa_q[rd_ptr_q] != '0);
            wr_addr_d = fa_q[rd_ptr_q];
            wr_data_d = fd_q[rd_ptr_q];
        end else if (bypass) begin
            wr_en_d   = (md_addr != '0);
            wr_addr_d = md_addr;
            wr_data_d = md_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
            end
            live_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            fa_q      <= fa_d;
            fd_q      <= fd_d;
            live_q    <= live_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign in_en    = wr_en_q ? ({{(NREGS-1){1'b0}}, 1'b1} << wr_addr_q) : '0;
    assign pend_cnt = cnt_q;
    assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose : self-checking bench for regfile_wb_arbiter against a queue-based reference model.
// Latency : one step() per clock; outputs sampled 1 time unit after the posedge.
// Backpr. : md_valid driven from the model's view of readiness; DUT md_ready compared each step.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        clr;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] in_en;
    logic [2:0]  pend_cnt;
    logic        busy;

    regfile_wb_arbiter dut (
        .clk(clk), .clr(clr),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .in_en(in_en),
        .pend_cnt(pend_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          exp_wr_en, exp_ready, obs_ready, acc;
    logic [4:0]  exp_wr_addr;
    logic [31:0] exp_wr_data;
    int          exp_cnt;

    // One clock of stimulus; the model decides what the write port should show next.
    task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md);
        ent_t e;
        bit   byp;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        md_valid  = mv; md_addr  = ma; md_data  = md;
        #2;
        obs_ready = md_ready;
        exp_ready = (q.size() < 4);
        acc = mv && exp_ready;
        byp = 1'b0;
`ifdef WB_BYPASS_EN
        byp = acc && !av && (q.size() == 0);
`endif
        exp_wr_en = 1'b0;
        if (av) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].addr == aa) begin
                    e = q[i]; e.live = 1'b0; q[i] = e;
                end
            end
            exp_wr_en = (aa != 0); exp_wr_addr = aa; exp_wr_data = ad;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_wr_en = e.live && (e.addr != 0); exp_wr_addr = e.addr; exp_wr_data = e.data;
        end else if (byp) begin
            exp_wr_en = (ma != 0); exp_wr_addr = ma; exp_wr_data = md;
        end
        if (acc && !byp) begin
            e.addr = ma; e.data = md; e.live = !(av && (ma == aa));
            q.push_back(e);
        end
        exp_cnt = q.size();
        @(posedge clk); #1;
    endtask

    task automatic do_clr(input int n, input bit mv);
        clr = 1'b1; alu_valid = 1'b0; md_valid = mv;
        md_addr = 5'($urandom_range(1, 31)); md_data = $urandom;
        repeat (n) @(posedge clk);
        #1;
        clr = 1'b0; md_valid = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_clr(2, 1'b1);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        checks++; if (in_en !== 32'h0) begin errors++; $display("FAIL reset_in_en: got %h want 0", in_en); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL reset_pend: got %0d want 0", pend_cnt); end
        checks++; if (wr_addr !== 5'd0 || wr_data !== 32'h0) begin
            errors++; $display("FAIL reset_wr_bus: got addr %0d data %h want 0 0", wr_addr, wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        #1;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %0b want 1", md_ready); end
    endtask

    task automatic test_alu_single();
        step(1'b1, 5'd5, 32'hDEAD0001, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL alu_wr_en: got %0b want 1", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL alu_wr_addr: got %0d want 5", wr_addr); end
        checks++; if (in_en !== 32'h0000_0020) begin errors++; $display("FAIL alu_in_en: got %h want 00000020", in_en); end
        checks++; if (wr_data !== 32'hDEAD0001) begin errors++; $display("FAIL alu_wr_data: got %h want dead0001", wr_data); end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b0 || in_en !== 32'h0) begin
            errors++; $display("FAIL alu_idle: got wr_en %0b in_en %h want 0 0", wr_en, in_en); end
    endtask

    task automatic test_md_then_alu();
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
`ifdef WB_BYPASS_EN
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h11 || pend_cnt !== 3'd0) begin
            errors++; $display("FAIL md_bypass: got en %0b addr %0d data %h pend %0d want 1 7 11 0",
                               wr_en, wr_addr, wr_data, pend_cnt); end
`else
        checks++; if (wr_en !== 1'b0 || pend_cnt !== 3'd1) begin
            errors++; $display("FAIL md_queued: got en %0b pend %0d want 0 1", wr_en, pend_cnt); end
`endif
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h33) begin
            errors++; $display("FAIL md_alu_first: got en %0b addr %0d data %h want 1 3 33", wr_en, wr_addr, wr_data); end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL md_after: got en %0b want 0", wr_en); end
`else
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h11 || in_en !== 32'h80) begin
            errors++; $display("FAIL md_late_write: got en %0b addr %0d data %h in_en %h want 1 7 11 00000080",
                               wr_en, wr_addr, wr_data, in_en); end
`endif
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL md_drain: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_starve();
        int k = 0;
        int nw = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 5'(20 + c), $urandom, k < 5, 5'(10 + k), 32'h100 + k);
            if (acc) k++;
        end
        checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL starve_pend: got %0d want 4", pend_cnt); end
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL starve_ready: got %0b want 0", obs_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL starve_busy: got %0b want 1", busy); end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 5'd0, 32'h0, k < 5, 5'(10 + k), 32'h100 + k);
            if (acc) k++;
            if (wr_en === 1'b1) begin
                checks++;
                if (wr_addr !== 5'(10 + nw) || wr_data !== 32'h100 + nw) begin
                    errors++; $display("FAIL starve_order: got addr %0d data %h want %0d %h",
                                       wr_addr, wr_data, 10 + nw, 32'h100 + nw); end
                nw++;
            end
        end
        checks++; if (nw !== 5) begin errors++; $display("FAIL starve_count: got %0d writes want 5", nw); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL starve_empty: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_squash();
        step(1'b1, 5'd9, 32'hBB, 1'b1, 5'd9, 32'hAA);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hBB || pend_cnt !== 3'd1) begin
            errors++; $display("FAIL squash_alu: got en %0b addr %0d data %h pend %0d want 1 9 bb 1",
                               wr_en, wr_addr, wr_data, pend_cnt); end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b0 || in_en !== 32'h0 || pend_cnt !== 3'd0) begin
            errors++; $display("FAIL squash_dead_pop: got en %0b in_en %h pend %0d want 0 0 0", wr_en, in_en, pend_cnt); end
        // older buffered entry killed by a later ALU write
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0);
        step(1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL squash_older: got en %0b want 0", wr_en); end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd13 || wr_data !== 32'hD0) begin
            errors++; $display("FAIL squash_survivor: got en %0b addr %0d data %h want 1 13 d0", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_addr0_clr();
        step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
        checks++; if (wr_en !== 1'b0 || in_en !== 32'h0) begin
            errors++; $display("FAIL addr0: got en %0b in_en %h want 0 0", wr_en, in_en); end
        for (int c = 0; c < 3; c++) step(1'b1, 5'd1, 32'h0, 1'b1, 5'(11 + c), 32'hE0 + c);
        checks++; if (pend_cnt !== 3'd3) begin errors++; $display("FAIL clr_prefill: got %0d want 3", pend_cnt); end
        do_clr(1, 1'b0);
        checks++; if (pend_cnt !== 3'd0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL clr_mid: got pend %0d en %0b want 0 0", pend_cnt, wr_en); end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL clr_no_write: got en %0b want 0", wr_en); end
        end
    endtask

    task automatic test_random();
        bit [31:0] exp_in;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
            exp_in = exp_wr_en ? (32'h1 << exp_wr_addr) : 32'h0;
            checks++; if (obs_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, obs_ready, exp_ready); end
            checks++; if (wr_en !== exp_wr_en) begin
                errors++; $display("FAIL rnd_wr_en c%0d: got %0b want %0b", c, wr_en, exp_wr_en); end
            if (exp_wr_en) begin
                checks++; if (wr_addr !== exp_wr_addr || wr_data !== exp_wr_data) begin
                    errors++; $display("FAIL rnd_wr c%0d: got %0d %h want %0d %h",
                                       c, wr_addr, wr_data, exp_wr_addr, exp_wr_data); end
            end
            checks++; if (in_en !== exp_in) begin
                errors++; $display("FAIL rnd_in_en c%0d: got %h want %h", c, in_en, exp_in); end
            checks++; if (pend_cnt !== 3'(exp_cnt) || busy !== (exp_cnt != 0)) begin
                errors++; $display("FAIL rnd_cnt c%0d: got %0d busy %0b want %0d", c, pend_cnt, busy, exp_cnt); end
        end
    endtask

    initial begin
        clr = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        #1;
        test_reset();
        test_alu_single();
        test_md_then_alu();
        test_starve();
        test_squash();
        test_addr0_clr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
